digit_recog_multi: RTL

- Parametrised successor to the single-row projection digit recogniser.
- Holds a table of up to MAX_CELLS digit bounding boxes, loaded by the projection stage.
- Per frame, extracts stroke features for every cell from the binarised pixel stream and classifies each cell as 0-9 or unknown.
- Streams results out one cell at a time over a valid/ready handshake. Sits between the projection/border block and the display/UART digit consumer.

---
 rtl/digit_recog_multi.sv | 303 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/digit_recog_multi.sv
// Multi-cell stroke-feature digit recogniser: holds a table of digit bounding boxes,
// accumulates scan-line and centre-column features per frame, then streams one code per cell.
module digit_recog_multi #(
    parameter int MAX_CELLS = 8,
    parameter int COORD_W   = 11,
    parameter int FRAC_W    = 6,
    parameter int F1        = 26,
    parameter int F2        = 43
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               box_wr,
    input  logic [3:0]         box_idx,
    input  logic [COORD_W-1:0] box_l,
    input  logic [COORD_W-1:0] box_r,
    input  logic [COORD_W-1:0] box_t,
    input  logic [COORD_W-1:0] box_b,
    input  logic [4:0]         num_cells,
    input  logic               pix_valid,
    input  logic               monoc,
    input  logic [COORD_W-1:0] xpos,
    input  logic [COORD_W-1:0] ypos,
    input  logic               frame_start,
    input  logic               frame_end,
    output logic               dig_valid,
    input  logic               dig_ready,
    output logic [3:0]         dig_code,
    output logic [3:0]         dig_idx,
    output logic               dig_last,
    output logic               busy,
    output logic               frame_drop
);

    localparam int PW = COORD_W + FRAC_W;

    typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, EMIT = 2'd2} state_t;

    state_t state_q, state_d;

    logic [COORD_W-1:0] l_q [MAX_CELLS];
    logic [COORD_W-1:0] r_q [MAX_CELLS];
    logic [COORD_W-1:0] t_q [MAX_CELLS];
    logic [COORD_W-1:0] b_q [MAX_CELLS];
    logic [COORD_W-1:0] y1_q[MAX_CELLS];
    logic [COORD_W-1:0] y2_q[MAX_CELLS];
    logic [COORD_W-1:0] xc_q[MAX_CELLS];

    logic [1:0]           vcnt_q[MAX_CELLS], vcnt_d[MAX_CELLS];
    logic [MAX_CELLS-1:0] x1l_q, x1l_d, x1r_q, x1r_d, x2l_q, x2l_d, x2r_q, x2r_d;
    logic [MAX_CELLS-1:0] vprev_q, vprev_d;
    logic                 h_prev_q, h_prev_d, row_valid_q, row_valid_d;
    logic [COORD_W-1:0]   last_y_q, last_y_d;
    logic [4:0]           ncell_q, ncell_d;

    logic       dig_valid_q, dig_valid_d, dig_last_q, dig_last_d;
    logic [3:0] dig_code_q, dig_code_d, dig_idx_q, dig_idx_d;
    logic       busy_q, busy_d, frame_drop_q, frame_drop_d;

    logic [PW-1:0]        diff_s, p1_s, p2_s;
    logic [COORD_W:0]     sum_s;
    logic [COORD_W-1:0]   y1_s, y2_s, xc_s;
    logic [MAX_CELLS-1:0] in_box_s;
    logic                 start_s, accum_s, hit_s, h_prev_eff_s, load_s;
    logic [3:0]           hit_idx_s, load_idx_s;
    logic [5:0]           key_s;

    function automatic logic [3:0] classify(input logic [5:0] key);
        logic [3:0] code;
        case (key)
            6'b10_1111: code = 4'd0;
            6'b01_1010: code = 4'd1;
            6'b11_0110: code = 4'd2;
            6'b11_0101: code = 4'd3;
            6'b10_1110: code = 4'd4;
            6'b11_1001: code = 4'd5;
            6'b11_1011: code = 4'd6;
            6'b10_0110: code = 4'd7;
            6'b11_1111: code = 4'd8;
            6'b11_1101: code = 4'd9;
            default:    code = 4'hF;
        endcase
        return code;
    endfunction

    // Scan-line rows and centre column derived from the incoming box (truncating fixed point)
    always_comb begin
        diff_s = PW'(box_b - box_t);
        p1_s   = diff_s * PW'(F1);
        p2_s   = diff_s * PW'(F2);
        y1_s   = box_t + COORD_W'(p1_s >> FRAC_W);
        y2_s   = box_t + COORD_W'(p2_s >> FRAC_W);
        sum_s  = {1'b0, box_l} + {1'b0, box_r};
        xc_s   = sum_s[COORD_W:1];
    end

    // Box table; writes accepted only while idle and for in-range indices
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_CELLS; i++) begin
                l_q[i]  <= {COORD_W{1'b0}};
                r_q[i]  <= {COORD_W{1'b0}};
                t_q[i]  <= {COORD_W{1'b0}};
                b_q[i]  <= {COORD_W{1'b0}};
                y1_q[i] <= {COORD_W{1'b0}};
                y2_q[i] <= {COORD_W{1'b0}};
                xc_q[i] <= {COORD_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < MAX_CELLS; i++) begin
                if (box_wr && (state_q == IDLE) && (box_idx == 4'(i))) begin
                    l_q[i]  <= box_l;
                    r_q[i]  <= box_r;
                    t_q[i]  <= box_t;
                    b_q[i]  <= box_b;
                    y1_q[i] <= y1_s;
                    y2_q[i] <= y2_s;
                    xc_q[i] <= xc_s;
                end
            end
        end
    end

    // Pixel-in-box test per active cell
    always_comb begin
        for (int i = 0; i < MAX_CELLS; i++) begin
            in_box_s[i] = (5'(i) < ncell_d) && (xpos >= l_q[i]) && (xpos <= r_q[i]) &&
                          (ypos >= t_q[i]) && (ypos <= b_q[i]);
        end
    end

    // Feature accumulation, frame FSM and result sequencing
    always_comb begin
        state_d     = state_q;
        ncell_d     = ncell_q;
        vcnt_d      = vcnt_q;
        x1l_d       = x1l_q;
        x1r_d       = x1r_q;
        x2l_d       = x2l_q;
        x2r_d       = x2r_q;
        vprev_d     = vprev_q;
        h_prev_d    = h_prev_q;
        row_valid_d = row_valid_q;
        last_y_d    = last_y_q;
        dig_valid_d = dig_valid_q;
        dig_code_d  = dig_code_q;
        dig_idx_d   = dig_idx_q;
        dig_last_d  = dig_last_q;
        hit_s       = 1'b0;
        hit_idx_s   = 4'd0;
        load_s      = 1'b0;
        load_idx_s  = 4'd0;
        key_s       = 6'd0;

        start_s = (state_q == IDLE) && frame_start && (num_cells != 5'd0);
        accum_s = start_s || (state_q == ACCUM);

        if (start_s) begin
            ncell_d = (num_cells > 5'(MAX_CELLS)) ? 5'(MAX_CELLS) : num_cells;
            for (int i = 0; i < MAX_CELLS; i++) begin
                vcnt_d[i] = 2'd0;
            end
            x1l_d       = {MAX_CELLS{1'b0}};
            x1r_d       = {MAX_CELLS{1'b0}};
            x2l_d       = {MAX_CELLS{1'b0}};
            x2r_d       = {MAX_CELLS{1'b0}};
            vprev_d     = {MAX_CELLS{1'b1}};
            row_valid_d = 1'b0;
        end else begin
            ncell_d = ncell_q;
        end

        // Descending scan so the lowest matching index wins
        hit_s = |in_box_s;
        for (int i = MAX_CELLS - 1; i >= 0; i--) begin
            hit_idx_s = in_box_s[i] ? 4'(i) : hit_idx_s;
        end

        h_prev_eff_s = (row_valid_d && (ypos == last_y_d)) ? h_prev_d : 1'b1;

        for (int i = 0; i < MAX_CELLS; i++) begin
            vcnt_d[i] = (accum_s && pix_valid && hit_s && (hit_idx_s == 4'(i)) &&
                         (xpos == xc_q[i]) && vprev_d[i] && !monoc && (vcnt_d[i] != 2'd3)) ?
                        vcnt_d[i] + 2'd1 : vcnt_d[i];
            vprev_d[i] = (accum_s && pix_valid && hit_s && (hit_idx_s == 4'(i)) &&
                          (xpos == xc_q[i])) ? monoc : vprev_d[i];
            x1l_d[i] = x1l_d[i] | (accum_s && pix_valid && hit_s && (hit_idx_s == 4'(i)) &&
                       h_prev_eff_s && !monoc && (ypos == y1_q[i]) && (xpos <= xc_q[i]));
            x1r_d[i] = x1r_d[i] | (accum_s && pix_valid && hit_s && (hit_idx_s == 4'(i)) &&
                       h_prev_eff_s && !monoc && (ypos == y1_q[i]) && (xpos > xc_q[i]));
            x2l_d[i] = x2l_d[i] | (accum_s && pix_valid && hit_s && (hit_idx_s == 4'(i)) &&
                       h_prev_eff_s && !monoc && (ypos == y2_q[i]) && (xpos <= xc_q[i]));
            x2r_d[i] = x2r_d[i] | (accum_s && pix_valid && hit_s && (hit_idx_s == 4'(i)) &&
                       h_prev_eff_s && !monoc && (ypos == y2_q[i]) && (xpos > xc_q[i]));
        end

        h_prev_d    = (accum_s && pix_valid) ? monoc : h_prev_d;
        last_y_d    = (accum_s && pix_valid) ? ypos : last_y_d;
        row_valid_d = (accum_s && pix_valid) ? 1'b1 : row_valid_d;

        case (state_q)
            IDLE: begin
                if (start_s) begin
                    state_d = frame_end ? EMIT : ACCUM;
                    load_s  = frame_end;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCUM: begin
                if (frame_end) begin
                    state_d = EMIT;
                    load_s  = 1'b1;
                end else begin
                    state_d = ACCUM;
                end
            end
            EMIT: begin
                if (dig_valid_q && dig_ready && dig_last_q) begin
                    state_d     = IDLE;
                    dig_valid_d = 1'b0;
                end else if (dig_valid_q && dig_ready) begin
                    load_s     = 1'b1;
                    load_idx_s = dig_idx_q + 4'd1;
                end else begin
                    state_d = EMIT;
                end
            end
            default: begin
                state_d     = IDLE;
                dig_valid_d = 1'b0;
            end
        endcase

        // Classification uses next-state features so a same-cycle final pixel is included
        for (int i = 0; i < MAX_CELLS; i++) begin
            key_s = (load_idx_s == 4'(i)) ?
                    {vcnt_d[i], x1l_d[i], x1r_d[i], x2l_d[i], x2r_d[i]} : key_s;
        end

        if (load_s) begin
            dig_valid_d = 1'b1;
            dig_idx_d   = load_idx_s;
            dig_code_d  = classify(key_s);
            dig_last_d  = ({1'b0, load_idx_s} == (ncell_d - 5'd1));
        end else begin
            dig_idx_d = dig_idx_q;
        end

        busy_d       = (state_d != IDLE);
        frame_drop_d = (state_q == EMIT) && frame_start;
    end

    // State, features and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ncell_q      <= 5'd0;
            for (int i = 0; i < MAX_CELLS; i++) begin
                vcnt_q[i] <= 2'd0;
            end
            x1l_q        <= {MAX_CELLS{1'b0}};
            x1r_q        <= {MAX_CELLS{1'b0}};
            x2l_q        <= {MAX_CELLS{1'b0}};
            x2r_q        <= {MAX_CELLS{1'b0}};
            vprev_q      <= {MAX_CELLS{1'b1}};
            h_prev_q     <= 1'b1;
            row_valid_q  <= 1'b0;
            last_y_q     <= {COORD_W{1'b0}};
            dig_valid_q  <= 1'b0;
            dig_code_q   <= 4'd0;
            dig_idx_q    <= 4'd0;
            dig_last_q   <= 1'b0;
            busy_q       <= 1'b0;
            frame_drop_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ncell_q      <= ncell_d;
            vcnt_q       <= vcnt_d;
            x1l_q        <= x1l_d;
            x1r_q        <= x1r_d;
            x2l_q        <= x2l_d;
            x2r_q        <= x2r_d;
            vprev_q      <= vprev_d;
            h_prev_q     <= h_prev_d;
            row_valid_q  <= row_valid_d;
            last_y_q     <= last_y_d;
            dig_valid_q  <= dig_valid_d;
            dig_code_q   <= dig_code_d;
            dig_idx_q    <= dig_idx_d;
            dig_last_q   <= dig_last_d;
            busy_q       <= busy_d;
            frame_drop_q <= frame_drop_d;
        end
    end

    assign dig_valid  = dig_valid_q;
    assign dig_code   = dig_code_q;
    assign dig_idx    = dig_idx_q;
    assign dig_last   = dig_last_q;
    assign busy       = busy_q;
    assign frame_drop = frame_drop_q;

endmodule
